button_event_arbiter: RTL and testbench

- Turns N debounced button levels into discrete events (PRESS, RELEASE, LONG, REPEAT) and serializes them onto one valid/ready event stream for the rgb_sequencer control logic.
- Sits between the per-button debouncer instances and the sequencer mode FSM.
- Each button gets one pending-event slot. A round-robin arbiter shares the single output channel among the buttons.

---
 rtl/button_event_arbiter.sv | 173 +++++++++++++++++
 tb/tb_button_event_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// Debounced button levels -> PRESS/RELEASE/LONG/REPEAT events, one pending slot
// per button, round-robin serialized onto a single valid/ready event stream.

module button_event_fsm #(
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       take,
  input  logic       overflow_clear,
  output logic       slot_full,
  output logic [1:0] slot_type,
  output logic       overflow
);
  localparam int MAXT = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int CW   = $clog2(MAXT + 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST  = (REPEAT_TICKS == 0) ? '0 : CW'(REPEAT_TICKS - 1);

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;
  localparam logic [1:0] EV_REPEAT  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          gen;
  logic [1:0]    gen_type;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gen       = 1'b0;
    gen_type  = EV_PRESS;
    case (state)
      S_IDLE: if (btn) begin
        state_nxt = S_PRESSED;
        cnt_nxt   = '0;
        gen       = 1'b1;
        gen_type  = EV_PRESS;
      end
      S_PRESSED: if (!btn) begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        gen       = 1'b1;
        gen_type  = EV_RELEASE;
      end else if (cnt == LONG_LAST) begin
        state_nxt = S_HELD;
        cnt_nxt   = '0;
        gen       = 1'b1;
        gen_type  = EV_LONG;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
      S_HELD: if (!btn) begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        gen       = 1'b1;
        gen_type  = EV_RELEASE;
      end else if (REPEAT_TICKS != 0) begin
        // With repeats disabled the counter parks at 0 for the rest of the hold.
        if (cnt == REP_LAST) begin
          cnt_nxt  = '0;
          gen      = 1'b1;
          gen_type = EV_REPEAT;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      slot_full <= 1'b0;
      slot_type <= '0;
      overflow  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      // Overwrite is only lossy when the old event is not leaving this same edge.
      overflow <= (gen & slot_full & ~take) | (overflow & ~overflow_clear);
      if (gen) begin
        slot_full <= 1'b1;
        slot_type <= gen_type;
      end else if (take) begin
        slot_full <= 1'b0;
      end
    end
  end
endmodule

module button_event_arbiter #(
  parameter int N_BUTTONS    = 4,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 250,
  localparam int IW          = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn_in,
  input  logic                 event_ready,
  input  logic                 overflow_clear,
  output logic                 event_valid,
  output logic [IW-1:0]        event_id,
  output logic [1:0]           event_type,
  output logic [N_BUTTONS-1:0] overflow
);
  logic [N_BUTTONS-1:0]      slot_full, take;
  logic [N_BUTTONS-1:0][1:0] slot_type;
  logic [IW-1:0]             ptr, gnt_idx;
  logic [1:0]                gnt_type;
  logic                      found, loadable;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
    button_event_fsm #(.LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_btn (
      .clk           (clk),
      .rst           (rst),
      .btn           (btn_in[g]),
      .take          (take[g]),
      .overflow_clear(overflow_clear),
      .slot_full     (slot_full[g]),
      .slot_type     (slot_type[g]),
      .overflow      (overflow[g])
    );
  end

  assign loadable = !event_valid || event_ready;

  // Rotating priority as two passes: indices at/after ptr first, then the wrap.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    gnt_type = '0;
    for (int i = 0; i < N_BUTTONS; i++)
      if (!found && IW'(i) >= ptr && slot_full[i]) begin
        found = 1'b1; gnt_idx = IW'(i); gnt_type = slot_type[i];
      end
    for (int i = 0; i < N_BUTTONS; i++)
      if (!found && IW'(i) < ptr && slot_full[i]) begin
        found = 1'b1; gnt_idx = IW'(i); gnt_type = slot_type[i];
      end
    take = '0;
    for (int i = 0; i < N_BUTTONS; i++)
      take[i] = loadable && found && (gnt_idx == IW'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      event_valid <= 1'b0;
      event_id    <= '0;
      event_type  <= '0;
      ptr         <= '0;
    end else if (loadable) begin
      event_valid <= found;
      if (found) begin
        event_id   <= gnt_idx;
        event_type <= gnt_type;
        ptr        <= (int'(gnt_idx) == N_BUTTONS - 1) ? '0 : gnt_idx + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench: vector table for multi-button ordering, hand sequences for
// long hold, backpressure/overflow, repeat-disabled variant and reset mid-hold.

module tb_button_event_arbiter;
  typedef struct { int c; int id; int t; } ev_t;
  typedef struct { logic [3:0] btn; int v; int id; int t; int ovf; } vec_t;

  logic       clk, rst, event_ready, overflow_clear;
  logic [3:0] btn_in;
  logic       ev_valid, ev0_valid;
  logic [1:0] ev_id, ev_type, ev0_id, ev0_type;
  logic [3:0] ovf, ovf0;

  int   checks = 0, errors = 0, cyc_n = 0;
  int   s_v, s_id, s_t, s_ovf;
  ev_t  q[$], q0[$], eq[$];

  button_event_arbiter #(.N_BUTTONS(4), .LONG_TICKS(8), .REPEAT_TICKS(4)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .event_ready(event_ready),
    .overflow_clear(overflow_clear), .event_valid(ev_valid), .event_id(ev_id),
    .event_type(ev_type), .overflow(ovf));

  button_event_arbiter #(.N_BUTTONS(4), .LONG_TICKS(8), .REPEAT_TICKS(0)) dut0 (
    .clk(clk), .rst(rst), .btn_in(btn_in), .event_ready(event_ready),
    .overflow_clear(overflow_clear), .event_valid(ev0_valid), .event_id(ev0_id),
    .event_type(ev0_type), .overflow(ovf0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  function automatic ev_t ev(input int c, input int id, input int t);
    ev_t e;
    e.c = c; e.id = id; e.t = t;
    return e;
  endfunction

  task automatic chk_q(input string nm, input ev_t got[$], input ev_t exp[$]);
    chk({nm, ".count"}, got.size(), exp.size());
    foreach (exp[i])
      if (i < got.size()) begin
        chk($sformatf("%s[%0d].cycle", nm, i), got[i].c, exp[i].c);
        chk($sformatf("%s[%0d].id", nm, i), got[i].id, exp[i].id);
        chk($sformatf("%s[%0d].type", nm, i), got[i].t, exp[i].t);
      end
  endtask

  // Sample outputs at the start of a cycle, log transfers, then drive this cycle's inputs.
  task automatic cyc(input logic [3:0] b, input logic r, input logic oc);
    @(negedge clk);
    cyc_n++;
    s_v = int'(ev_valid); s_id = int'(ev_id); s_t = int'(ev_type); s_ovf = int'(ovf);
    if (ev_valid && r)  q.push_back(ev(cyc_n, int'(ev_id), int'(ev_type)));
    if (ev0_valid && r) q0.push_back(ev(cyc_n, int'(ev0_id), int'(ev0_type)));
    btn_in = b; event_ready = r; overflow_clear = oc;
  endtask

  task automatic chk_out(input string nm, input int v, input int id, input int t, input int o);
    chk({nm, ".valid"}, s_v, v);
    chk({nm, ".id"}, s_id, id);
    chk({nm, ".type"}, s_t, t);
    chk({nm, ".overflow"}, s_ovf, o);
  endtask

  initial begin
    vec_t tv[20];
    int p;
    tv[0]  = '{4'b1011, 0, 0, 0, 0};
    tv[1]  = '{4'b1011, 0, 0, 0, 0};
    tv[2]  = '{4'b1011, 1, 0, 0, 0};
    tv[3]  = '{4'b1000, 1, 1, 0, 0};
    tv[4]  = '{4'b1000, 1, 3, 0, 0};
    tv[5]  = '{4'b1000, 1, 0, 1, 0};
    tv[6]  = '{4'b0001, 1, 1, 1, 0};
    tv[7]  = '{4'b0001, 0, 1, 1, 0};
    tv[8]  = '{4'b0001, 1, 3, 1, 0};
    tv[9]  = '{4'b0000, 1, 0, 0, 0};
    tv[10] = '{4'b0000, 0, 0, 0, 0};
    tv[11] = '{4'b0000, 1, 0, 1, 0};
    tv[12] = '{4'b0000, 0, 0, 1, 0};
    tv[13] = '{4'b0100, 0, 0, 1, 0};
    tv[14] = '{4'b0100, 0, 0, 1, 0};
    tv[15] = '{4'b0100, 1, 2, 0, 0};
    tv[16] = '{4'b0000, 0, 2, 0, 0};
    tv[17] = '{4'b0000, 0, 2, 0, 0};
    tv[18] = '{4'b0000, 1, 2, 1, 0};
    tv[19] = '{4'b0000, 0, 2, 1, 0};

    rst = 1'b1; btn_in = '0; event_ready = 1'b1; overflow_clear = 1'b0;
    repeat (3) cyc(4'b0000, 1'b1, 1'b0);
    chk_out("reset", 0, 0, 0, 0);
    rst = 1'b0;

    // Simultaneous presses, pointer fairness, then a short press on button 2.
    foreach (tv[i]) begin
      cyc(tv[i].btn, 1'b1, 1'b0);
      chk_out($sformatf("vec%0d", i), tv[i].v, tv[i].id, tv[i].t, tv[i].ovf);
    end

    // Long hold with repeats on button 1.
    q.delete();
    cyc(4'b0010, 1'b1, 1'b0); p = cyc_n;
    repeat (20) cyc(4'b0010, 1'b1, 1'b0);
    repeat (6)  cyc(4'b0000, 1'b1, 1'b0);
    eq.delete();
    eq.push_back(ev(p + 2, 1, 0));  eq.push_back(ev(p + 10, 1, 2));
    eq.push_back(ev(p + 14, 1, 3)); eq.push_back(ev(p + 18, 1, 3));
    eq.push_back(ev(p + 22, 1, 3)); eq.push_back(ev(p + 23, 1, 1));
    chk_q("long_hold", q, eq);

    // Repeat-disabled instance: 30-cycle hold on button 3.
    q0.delete();
    cyc(4'b1000, 1'b1, 1'b0); p = cyc_n;
    repeat (29) cyc(4'b1000, 1'b1, 1'b0);
    repeat (6)  cyc(4'b0000, 1'b1, 1'b0);
    eq.delete();
    eq.push_back(ev(p + 2, 3, 0)); eq.push_back(ev(p + 10, 3, 2)); eq.push_back(ev(p + 32, 3, 1));
    chk_q("no_repeat", q0, eq);

    // Backpressure and overflow on button 0.
    repeat (4) cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0); chk_out("bp_idle", 0, 3, 1, 0);
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0); chk_out("bp_press", 1, 0, 0, 0);
    cyc(4'b0000, 1'b0, 1'b0); chk_out("bp_hold", 1, 0, 0, 0);
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0); chk_out("bp_ovf", 1, 0, 0, 1);
    q.delete();
    cyc(4'b0001, 1'b1, 1'b0);
    cyc(4'b0001, 1'b1, 1'b0); chk_out("bp_drain2", 1, 0, 0, 1);
    p = cyc_n - 1;
    cyc(4'b0000, 1'b1, 1'b1); chk_out("bp_clr_pend", 0, 0, 0, 1);
    cyc(4'b0000, 1'b1, 1'b0); chk_out("bp_cleared", 0, 0, 0, 0);
    cyc(4'b0000, 1'b1, 1'b0); chk_out("bp_release", 1, 0, 1, 0);
    eq.delete();
    eq.push_back(ev(p, 0, 0)); eq.push_back(ev(p + 1, 0, 0)); eq.push_back(ev(p + 4, 0, 1));
    chk_q("bp_drain", q, eq);

    // Take and write on the same edge: no overflow. Then set beats clear.
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b1); chk_out("take_write", 1, 0, 0, 0);
    cyc(4'b0000, 1'b0, 1'b0); chk(  "set_wins.overflow", s_ovf, 1);
    cyc(4'b0000, 1'b1, 1'b1); chk(  "ovf_sticky.overflow", s_ovf, 1);
    cyc(4'b0000, 1'b1, 1'b0); chk_out("ovf_drain", 1, 0, 1, 0);
    cyc(4'b0000, 1'b1, 1'b0); chk(  "ovf_empty.valid", s_v, 0);

    // Reset at hold cycle 5 with an event stalled on the output.
    repeat (3) cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0); p = cyc_n;
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0); chk_out("rst_pre", 1, 2, 0, 0);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0); chk(  "rst_pre2.valid", s_v, 1);
    rst = 1'b1;
    q.delete();
    cyc(4'b0100, 1'b1, 1'b0); chk_out("rst_post", 0, 0, 0, 0);
    rst = 1'b0;
    repeat (11) cyc(4'b0100, 1'b1, 1'b0);
    eq.delete();
    eq.push_back(ev(p + 8, 2, 0)); eq.push_back(ev(p + 16, 2, 2));
    chk_q("rst_fresh", q, eq);
    repeat (4) cyc(4'b0000, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
